// File: rtl/jk_excitation_driver.sv
// jk_excitation_driver
//    Drives a bank of WIDTH JK flops toward a requested target word, keeps a
//    shadow copy of the bank state, verifies the bank's q feedback after every
//    write and counts divergences in a saturating error counter.
//
//    Build option: define JK_TOGGLE_ENC_EN to use toggle encoding
//    (changed bits get j=k=1). Without it, set/clear encoding is used
//    (j = ~s & t, k = s & ~t).
//
//    state | meaning
//    ------+-----------------------------------------------------------
//    IDLE  | ready for a target; done/mismatch of the last write visible
//    DRIVE | j/k presented to the bank; bank captures at end of cycle
//    CHECK | bank q compared against shadow; resync shadow on mismatch
module jk_excitation_driver #(
   parameter int WIDTH     = 8,
   parameter int ERR_CNT_W = 8
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 tgt_valid,
   output logic                 tgt_ready,
   input  logic [WIDTH-1:0]     tgt_data,
   output logic [WIDTH-1:0]     jk_j,
   output logic [WIDTH-1:0]     jk_k,
   input  logic [WIDTH-1:0]     jk_q,
   output logic [WIDTH-1:0]     shadow_q,
   output logic                 busy,
   output logic                 done,
   output logic                 mismatch,
   output logic [ERR_CNT_W-1:0] err_cnt
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      DRIVE = 2'd1,
      CHECK = 2'd2
   } state_t;

   state_t           state;
   logic [WIDTH-1:0] tgt_lat;
   logic [WIDTH-1:0] exc_j;
   logic [WIDTH-1:0] exc_k;

   // Excitation needed to move each bank bit from the shadow value to the target
   always_comb begin
`ifdef JK_TOGGLE_ENC_EN
      exc_j = shadow_q ^ tgt_data;
      exc_k = shadow_q ^ tgt_data;
`else
      exc_j = ~shadow_q & tgt_data;
      exc_k = shadow_q & ~tgt_data;
`endif
   end

   assign tgt_ready = (state == IDLE);
   assign busy      = (state != IDLE);

   // Sequencer: accept, drive one cycle, verify one cycle, report
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state    <= IDLE;
         tgt_lat  <= '0;
         jk_j     <= '0;
         jk_k     <= '0;
         shadow_q <= '0;
         err_cnt  <= '0;
         done     <= 1'b0;
         mismatch <= 1'b0;
      end else begin
         done     <= 1'b0;
         mismatch <= 1'b0;
         case (state)
            IDLE: begin
               if (tgt_valid) begin
                  tgt_lat <= tgt_data;
                  jk_j    <= exc_j;
                  jk_k    <= exc_k;
                  state   <= DRIVE;
               end
            end
            DRIVE: begin
               jk_j     <= '0;
               jk_k     <= '0;
               shadow_q <= tgt_lat;
               state    <= CHECK;
            end
            CHECK: begin
               if (jk_q == shadow_q) begin
                  done <= 1'b1;
               end else begin
                  mismatch <= 1'b1;
                  shadow_q <= jk_q;
                  if (err_cnt != {ERR_CNT_W{1'b1}}) begin
                     err_cnt <= err_cnt + ERR_CNT_W'(1);
                  end
               end
               state <= IDLE;
            end
            default: begin
               jk_j  <= '0;
               jk_k  <= '0;
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_jk_excitation_driver.sv
// Self-checking bench for jk_excitation_driver: table-driven directed writes,
// error-counter saturation, asynchronous reset, backpressure and randomized
// writes against a transaction-level reference model. The JK bank is modelled
// here, with a stuck-at-1 fault mask on its q outputs.
module tb_jk_excitation_driver;

   localparam int W  = 8;
   localparam int EW = 8;

   logic          clk = 1'b0;
   logic          reset;
   logic          tgt_valid;
   logic          tgt_ready;
   logic [W-1:0]  tgt_data;
   logic [W-1:0]  jk_j;
   logic [W-1:0]  jk_k;
   logic [W-1:0]  jk_q;
   logic [W-1:0]  shadow_q;
   logic          busy;
   logic          done;
   logic          mismatch;
   logic [EW-1:0] err_cnt;

   logic [W-1:0]  bank;
   logic [W-1:0]  stuck;

   int checks = 0;
   int errors = 0;

   logic [W-1:0] m_bank;
   logic [W-1:0] m_shadow;
   int           m_err;

   logic [W-1:0] acc_q[$];
   int           acc_cyc[$];
   int           cyc = 0;

   jk_excitation_driver #(.WIDTH(W), .ERR_CNT_W(EW)) dut (
      .clk       (clk),
      .reset     (reset),
      .tgt_valid (tgt_valid),
      .tgt_ready (tgt_ready),
      .tgt_data  (tgt_data),
      .jk_j      (jk_j),
      .jk_k      (jk_k),
      .jk_q      (jk_q),
      .shadow_q  (shadow_q),
      .busy      (busy),
      .done      (done),
      .mismatch  (mismatch),
      .err_cnt   (err_cnt)
   );

   always #5 clk = ~clk;

   // JK flop bank with optional stuck-at-1 bits on its outputs
   always_ff @(posedge clk or posedge reset) begin
      if (reset) bank <= '0;
      else       bank <= (jk_j & ~bank) | (~jk_k & bank);
   end
   assign jk_q = bank | stuck;

   // Log every accepted target and the cycle it was taken in
   always @(posedge clk) begin
      cyc++;
      if (!reset && tgt_valid && tgt_ready) begin
         acc_q.push_back(tgt_data);
         acc_cyc.push_back(cyc);
      end
   end

   initial begin
      #400000;
      $display("FAIL watchdog: simulation time limit reached, required finish earlier");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
      end
   endtask

   function automatic void model_exc(input logic [W-1:0] s, input logic [W-1:0] t,
                                     output logic [W-1:0] j, output logic [W-1:0] k);
`ifdef JK_TOGGLE_ENC_EN
      j = s ^ t;
      k = s ^ t;
`else
      j = ~s & t;
      k = s & ~t;
`endif
   endfunction

   // Predict one write: excitation, bank result, verdict, shadow and error count
   task automatic model_step(input logic [W-1:0] t, input logic [W-1:0] stk,
                             output logic [W-1:0] ej, output logic [W-1:0] ek,
                             output logic edone, output logic [W-1:0] esh,
                             output logic [EW-1:0] eerr);
      logic [W-1:0] obs;
      model_exc(m_shadow, t, ej, ek);
      m_bank = (ej & ~m_bank) | (~ek & m_bank);
      obs    = m_bank | stk;
      edone  = (obs == t);
      if (!edone && m_err < 255) m_err++;
      m_shadow = obs;
      esh      = obs;
      eerr     = EW'(m_err);
   endtask

   function automatic void model_reset();
      m_bank   = '0;
      m_shadow = '0;
      m_err    = 0;
   endfunction

   // One full write starting at a negedge in IDLE; ends at the negedge of the report cycle
   task automatic do_write(input string tag, input logic [W-1:0] t, input logic [W-1:0] stk,
                           input logic [W-1:0] ej, input logic [W-1:0] ek,
                           input logic edone, input logic [W-1:0] esh, input logic [EW-1:0] eerr);
      int n = 0;
      stuck     = stk;
      tgt_data  = t;
      tgt_valid = 1'b1;
      while (!tgt_ready && n < 10) begin
         @(negedge clk);
         n++;
      end
      if (!tgt_ready) begin
         chk({tag, "_accept_timeout"}, 32'(tgt_ready), 32'd1);
         tgt_valid = 1'b0;
         return;
      end
      @(negedge clk);
      tgt_valid = 1'b0;
      tgt_data  = W'($urandom);
      chk({tag, "_drive_busy"}, 32'(busy), 32'd1);
      chk({tag, "_drive_ready"}, 32'(tgt_ready), 32'd0);
      chk({tag, "_drive_j"}, 32'(jk_j), 32'(ej));
      chk({tag, "_drive_k"}, 32'(jk_k), 32'(ek));
      @(negedge clk);
      chk({tag, "_check_jk"}, 32'(jk_j | jk_k), 32'd0);
      chk({tag, "_check_shadow"}, 32'(shadow_q), 32'(t));
      @(negedge clk);
      chk({tag, "_done"}, 32'(done), 32'(edone));
      chk({tag, "_mismatch"}, 32'(mismatch), 32'(!edone));
      chk({tag, "_shadow"}, 32'(shadow_q), 32'(esh));
      chk({tag, "_err_cnt"}, 32'(err_cnt), 32'(eerr));
      chk({tag, "_ready"}, 32'(tgt_ready), 32'd1);
   endtask

   typedef struct {
      string        name;
      logic [W-1:0] tgt;
      logic [W-1:0] stk;
      logic [W-1:0] ej;
      logic [W-1:0] ek;
      logic         edone;
      logic [W-1:0] esh;
      logic [EW-1:0] eerr;
   } vec_t;

   initial begin
      vec_t         tbl[4];
      logic [W-1:0] ej, ek, esh, t, stk;
      logic [EW-1:0] eerr;
      logic         edone;

`ifdef JK_TOGGLE_ENC_EN
      tbl[0] = '{"w_a5",    8'hA5, 8'h00, 8'hA5, 8'hA5, 1'b1, 8'hA5, 8'd0};
      tbl[1] = '{"w_3c",    8'h3C, 8'h00, 8'h99, 8'h99, 1'b1, 8'h3C, 8'd0};
      tbl[2] = '{"w_a5b",   8'hA5, 8'h00, 8'h99, 8'h99, 1'b1, 8'hA5, 8'd0};
      tbl[3] = '{"w_stuck", 8'h00, 8'h01, 8'hA5, 8'hA5, 1'b0, 8'h01, 8'd1};
`else
      tbl[0] = '{"w_a5",    8'hA5, 8'h00, 8'hA5, 8'h00, 1'b1, 8'hA5, 8'd0};
      tbl[1] = '{"w_3c",    8'h3C, 8'h00, 8'h18, 8'h81, 1'b1, 8'h3C, 8'd0};
      tbl[2] = '{"w_a5b",   8'hA5, 8'h00, 8'h81, 8'h18, 1'b1, 8'hA5, 8'd0};
      tbl[3] = '{"w_stuck", 8'h00, 8'h01, 8'h00, 8'hA5, 1'b0, 8'h01, 8'd1};
`endif

      reset     = 1'b1;
      tgt_valid = 1'b0;
      tgt_data  = '0;
      stuck     = '0;
      model_reset();
      repeat (2) @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      chk("rst_j", 32'(jk_j), 32'd0);
      chk("rst_k", 32'(jk_k), 32'd0);
      chk("rst_shadow", 32'(shadow_q), 32'd0);
      chk("rst_err", 32'(err_cnt), 32'd0);
      chk("rst_ready", 32'(tgt_ready), 32'd1);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_done", 32'(done | mismatch), 32'd0);

      for (int i = 0; i < 4; i++) begin
         model_step(tbl[i].tgt, tbl[i].stk, ej, ek, edone, esh, eerr);
         do_write(tbl[i].name, tbl[i].tgt, tbl[i].stk,
                  tbl[i].ej, tbl[i].ek, tbl[i].edone, tbl[i].esh, tbl[i].eerr);
      end

      for (int i = 0; i < 300; i++) begin
         model_step(8'h00, 8'h01, ej, ek, edone, esh, eerr);
         do_write("sat", 8'h00, 8'h01, ej, ek, edone, esh, eerr);
      end
      chk("sat_err_max", 32'(err_cnt), 32'hFF);

      stuck = '0;
      model_step(8'h5A, 8'h00, ej, ek, edone, esh, eerr);
      do_write("pre_rst", 8'h5A, 8'h00, ej, ek, edone, esh, eerr);
      #2 reset = 1'b1;
      #1;
      chk("arst_shadow", 32'(shadow_q), 32'd0);
      chk("arst_err", 32'(err_cnt), 32'd0);
      chk("arst_jk", 32'(jk_j | jk_k), 32'd0);
      chk("arst_bank", 32'(jk_q), 32'd0);
      @(negedge clk);
      reset = 1'b0;
      model_reset();
      @(negedge clk);

      acc_q.delete();
      acc_cyc.delete();
      tgt_valid = 1'b1;
      tgt_data  = 8'h11;
      @(negedge clk);
      tgt_data = 8'h22;
      model_exc(8'h00, 8'h11, ej, ek);
      chk("bp_drive1_ready", 32'(tgt_ready), 32'd0);
      chk("bp_drive1_j", 32'(jk_j), 32'(ej));
      chk("bp_drive1_k", 32'(jk_k), 32'(ek));
      @(negedge clk);
      chk("bp_check1_ready", 32'(tgt_ready), 32'd0);
      @(negedge clk);
      chk("bp_done1", 32'(done), 32'd1);
      chk("bp_idle_ready", 32'(tgt_ready), 32'd1);
      chk("bp_shadow1", 32'(shadow_q), 32'h11);
      @(negedge clk);
      tgt_valid = 1'b0;
      model_exc(8'h11, 8'h22, ej, ek);
      chk("bp_drive2_ready", 32'(tgt_ready), 32'd0);
      chk("bp_drive2_j", 32'(jk_j), 32'(ej));
      chk("bp_drive2_k", 32'(jk_k), 32'(ek));
      @(negedge clk);
      @(negedge clk);
      chk("bp_done2", 32'(done), 32'd1);
      chk("bp_shadow2", 32'(shadow_q), 32'h22);
      chk("bp_accept_count", 32'(acc_q.size()), 32'd2);
      if (acc_q.size() == 2) begin
         chk("bp_accept0", 32'(acc_q[0]), 32'h11);
         chk("bp_accept1", 32'(acc_q[1]), 32'h22);
         chk("bp_spacing", 32'(acc_cyc[1] - acc_cyc[0]), 32'd3);
      end
      m_bank   = 8'h22;
      m_shadow = 8'h22;

      for (int i = 0; i < 40; i++) begin
         t   = W'($urandom);
         stk = ($urandom_range(0, 3) == 0) ? W'($urandom) : '0;
         if ($urandom_range(0, 4) == 0) t = m_shadow;
         model_step(t, stk, ej, ek, edone, esh, eerr);
         do_write("rnd", t, stk, ej, ek, edone, esh, eerr);
         repeat ($urandom_range(0, 2)) @(negedge clk);
      end

      stuck     = '0;
      tgt_valid = 1'b1;
      tgt_data  = 8'hFF;
      model_exc(m_shadow, 8'hFF, ej, ek);
      @(negedge clk);
      tgt_valid = 1'b0;
      chk("rdrv_j_before", 32'(jk_j), 32'(ej));
      #2 reset = 1'b1;
      #1;
      chk("rdrv_j", 32'(jk_j), 32'd0);
      chk("rdrv_k", 32'(jk_k), 32'd0);
      chk("rdrv_busy", 32'(busy), 32'd0);
      chk("rdrv_ready", 32'(tgt_ready), 32'd1);
      chk("rdrv_err", 32'(err_cnt), 32'd0);
      @(negedge clk);
      reset = 1'b0;
      model_reset();
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk("rdrv_no_pulse", 32'(done | mismatch), 32'd0);
         chk("rdrv_idle", 32'(busy), 32'd0);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/jk_excitation_driver.md
Name: jk_excitation_driver

Overview:
- Drives a bank of WIDTH JK flip-flops (j/k/q interface) toward a requested target word.
- Converts "desired next state" into per-bit J/K excitation; it is the upstream controller of the JK flop.
- Keeps a shadow copy of the bank state and checks the bank's q feedback after every write.
- Counts and reports any divergence between the bank and the shadow.

Parameters:
- WIDTH, 8, number of JK flops in the driven bank.
- ERR_CNT_W, 8, width of the saturating mismatch counter.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-high reset.
- tgt_valid  input  1  target word offered.
- tgt_ready  output  1  block can accept a target this cycle.
- tgt_data  input  WIDTH  desired bank state.
- jk_j  output  WIDTH  J inputs to the flop bank (registered).
- jk_k  output  WIDTH  K inputs to the flop bank (registered).
- jk_q  input  WIDTH  q feedback from the flop bank (same clk, same reset).
- shadow_q  output  WIDTH  expected bank state.
- busy  output  1  FSM not in IDLE.
- done  output  1  one-cycle pulse: write verified.
- mismatch  output  1  one-cycle pulse: write failed verification.
- err_cnt  output  ERR_CNT_W  saturating mismatch count.

Behaviour:
- Reset (async, active-high):
  - state=IDLE; jk_j=0, jk_k=0; shadow_q=0 (matches the flop bank's reset value); err_cnt=0; done=0, mismatch=0.
  - Reset asserted mid-operation aborts the write; j/k are forced to 0 immediately, so the bank holds or is itself reset.
- FSM states:
  - IDLE:
    - tgt_ready=1, busy=0.
    - On tgt_valid&&tgt_ready: latch tgt_data; load jk_j/jk_k per the excitation rule; go to DRIVE.
  - DRIVE (exactly 1 cycle):
    - jk_j/jk_k are presented to the bank; the bank captures them at the end of this cycle.
    - On that edge: jk_j=jk_k=0; shadow_q <= target; go to CHECK.
  - CHECK (exactly 1 cycle):
    - If jk_q==shadow_q: done=1 in the next cycle.
    - Otherwise: mismatch=1 in the next cycle; err_cnt+1, saturating at all-ones; shadow_q <= jk_q (resync).
    - Go to IDLE.
- Excitation rule (set/clear encoding), per bit with s=shadow_q, t=target:
  - j = ~s & t
  - k = s & ~t
  - Don't-care excitations are driven as 0.
- Outside DRIVE, j=k=0 (bank holds).
- Latency and throughput:
  - Accept edge to done pulse = 3 cycles.
  - Throughput is 1 target per 3 cycles.
  - done/mismatch are asserted during the first IDLE cycle; a new target may be accepted in that same cycle.
- Boundary conditions:
  - Target equal to shadow: still walks DRIVE/CHECK with j=k=0 and reports done.
  - tgt_valid held while busy: tgt_ready=0; the input is not consumed; the offer is accepted on return to IDLE.
  - tgt_data changing while busy: ignored (target was latched at accept).
  - err_cnt at max: stays at max; mismatch still pulses.

Optional Feature:
- Macro: JK_TOGGLE_ENC_EN.
- Defined: toggle encoding. Changed bits get j=k=1; unchanged bits get j=k=0 (j = k = s ^ t). All other timing and checking is identical.
- Undefined: set/clear encoding as given in Behaviour.

Test Plan:
- Reset then idle:
  - Required: j=k=0, shadow_q=0x00, err_cnt=0, tgt_ready=1.
  - Pulse reset with the bank at a nonzero value -> all outputs 0 asynchronously.
- Write 0xA5 from reset:
  - DRIVE cycle j=0xA5, k=0x00.
  - CHECK with jk_q=0xA5 -> done pulse; shadow_q=0xA5; 3 cycles from accept to done.
- Then write 0x3C:
  - Set/clear encoding: j=0x18, k=0x81.
  - With JK_TOGGLE_ENC_EN: j=k=0x99.
  - Either way: jk_q=0x3C and done.
- Bank bit 0 stuck at 1, write 0x00 from 0xA5:
  - mismatch pulse; err_cnt=1; shadow_q=0x01 after resync.
  - Repeat 300 failing writes -> err_cnt saturates at 0xFF.
- Backpressure: tgt_valid held high with data 0x11 then 0x22:
  - tgt_ready low in DRIVE/CHECK.
  - Exactly one accept per 3 cycles; no target lost or duplicated.
- Reset asserted during DRIVE of 0xFF:
  - j/k drop to 0 immediately; state IDLE; no done/mismatch pulse; err_cnt=0.
